// File: rtl/pacman_pkg.sv
// Shared definitions for the maze movers: heading codes, FSM states and map geometry.
package pacman_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_NONE  = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRY_NEXT = 2'd1,
    ST_TRY_CUR  = 2'd2
  } state_e;

  localparam int MAP_W    = 27;
  localparam int MAP_H    = 24;
  localparam int TUNNEL_Y = 10;

  // Fixed key priority: up > down > left > right; no key keeps the old request.
  function automatic dir_e key_dir(input logic up, input logic dn, input logic lf,
                                   input logic rt, input dir_e hold);
    if (up)      return DIR_UP;
    else if (dn) return DIR_DOWN;
    else if (lf) return DIR_LEFT;
    else if (rt) return DIR_RIGHT;
    else         return hold;
  endfunction

endpackage

// File: rtl/tile_step.sv
// Combinational neighbour-tile computation: position plus heading gives target and legality.
// Illegal targets (edge of map, NONE) report the input position unchanged.
module tile_step #(
  parameter int MAP_W    = pacman_pkg::MAP_W,
  parameter int MAP_H    = pacman_pkg::MAP_H,
  parameter int TUNNEL_Y = pacman_pkg::TUNNEL_Y
) (
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] dir,
  output logic [7:0] tx,
  output logic [6:0] ty,
  output logic       legal
);
  import pacman_pkg::*;

  always_comb begin
    tx    = x;
    ty    = y;
    legal = 1'b0;
    case (dir)
      DIR_UP: begin
        if (y != 7'd0) begin
          ty    = y - 7'd1;
          legal = 1'b1;
        end
      end
      DIR_DOWN: begin
        if (y < 7'(MAP_H - 1)) begin
          ty    = y + 7'd1;
          legal = 1'b1;
        end
      end
      DIR_LEFT: begin
        if (x != 8'd0) begin
          tx    = x - 8'd1;
          legal = 1'b1;
        end else if (y == 7'(TUNNEL_Y)) begin
          tx    = 8'(MAP_W - 1);
          legal = 1'b1;
        end
      end
      DIR_RIGHT: begin
        if (x < 8'(MAP_W - 1)) begin
          tx    = x + 8'd1;
          legal = 1'b1;
        end else if (y == 7'(TUNNEL_Y)) begin
          tx    = 8'd0;
          legal = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pacman_mover.sv
// Player mover: on each tick tries the requested heading, falls back to the current heading,
// otherwise reports blocked. The wall bit comes from an external map LUT addressed by map_x/map_y.
module pacman_mover #(
  parameter int START_X  = 13,
  parameter int START_Y  = 18,
  parameter int MAP_W    = pacman_pkg::MAP_W,
  parameter int MAP_H    = pacman_pkg::MAP_H,
  parameter int TUNNEL_Y = pacman_pkg::TUNNEL_Y
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic [7:0] map_x,
  output logic [6:0] map_y,
  input  logic       map_wall,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic [2:0] cur_dir,
  output logic       moved,
  output logic       blocked,
  output logic       busy,
  output logic [1:0] dbg_state
);
  import pacman_pkg::*;

  // Handshake: tick is a one-cycle request accepted only while busy=0; a request
  // seen while busy=1 is dropped. Exactly one moved or blocked pulse answers it.

  state_e     r_state, w_state_nxt;
  dir_e       r_next_dir, r_try_dir, r_cur_dir;
  logic [7:0] r_pos_x, r_map_x;
  logic [6:0] r_pos_y, r_map_y;
  logic       r_legal, r_moved, r_blocked;

  logic       w_load_map, w_commit, w_adopt, w_block;
  logic [2:0] w_step_dir;
  logic [7:0] w_tx;
  logic [6:0] w_ty;
  logic       w_legal;

  // IDLE evaluates the requested heading; TRY_NEXT prepares the fallback on cur_dir.
  assign w_step_dir = (r_state == ST_IDLE) ? r_next_dir : r_cur_dir;

  tile_step #(
    .MAP_W   (MAP_W),
    .MAP_H   (MAP_H),
    .TUNNEL_Y(TUNNEL_Y)
  ) u_step (
    .x    (r_pos_x),
    .y    (r_pos_y),
    .dir  (w_step_dir),
    .tx   (w_tx),
    .ty   (w_ty),
    .legal(w_legal)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load_map  = 1'b0;
    w_commit    = 1'b0;
    w_adopt     = 1'b0;
    w_block     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tick) begin
          w_load_map  = 1'b1;
          w_state_nxt = ST_TRY_NEXT;
        end
      end
      ST_TRY_NEXT: begin
        if (r_legal && !map_wall) begin
          w_commit    = 1'b1;
          w_adopt     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_load_map  = 1'b1;
          w_state_nxt = ST_TRY_CUR;
        end
      end
      ST_TRY_CUR: begin
        if (r_legal && !map_wall) w_commit = 1'b1;
        else                      w_block  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_next_dir <= DIR_NONE;
      r_try_dir  <= DIR_NONE;
      r_cur_dir  <= DIR_NONE;
      r_pos_x    <= 8'(START_X);
      r_pos_y    <= 7'(START_Y);
      r_map_x    <= 8'(START_X);
      r_map_y    <= 7'(START_Y);
      r_legal    <= 1'b0;
      r_moved    <= 1'b0;
      r_blocked  <= 1'b0;
    end else begin
      r_next_dir <= key_dir(key_up, key_down, key_left, key_right, r_next_dir);
      r_moved    <= w_commit;
      r_blocked  <= w_block;
      // Latch the heading this tick actually used, so later key changes cannot leak in.
      if (r_state == ST_IDLE && tick) r_try_dir <= r_next_dir;
      if (w_load_map) begin
        r_legal <= w_legal;
        if (w_legal) begin
          r_map_x <= w_tx;
          r_map_y <= w_ty;
        end
      end
      if (w_commit) begin
        r_pos_x <= r_map_x;
        r_pos_y <= r_map_y;
      end
      if (w_adopt) r_cur_dir <= r_try_dir;
    end
  end

  assign map_x     = r_map_x;
  assign map_y     = r_map_y;
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign cur_dir   = r_cur_dir;
  assign moved     = r_moved;
  assign blocked   = r_blocked;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover with a small behavioural map (two walls above the start row)
// and an all-open stub mode for the tunnel and edge cases.
module tb_pacman_mover;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       tick = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic [7:0] map_x, pos_x;
  logic [6:0] map_y, pos_y;
  logic       map_wall;
  logic [2:0] cur_dir;
  logic       moved, blocked, busy;
  logic [1:0] dbg_state;
  logic       stub_map = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] keys;   // {up, down, left, right}
    logic       stub;
    int         ex;
    int         ey;
    int         edir;
    int         elat;
    logic       emoved;
  } vec_t;

  vec_t vecs[14];

  pacman_mover dut (
    .clock    (clock),
    .resetn   (resetn),
    .tick     (tick),
    .key_up   (key_up),
    .key_down (key_down),
    .key_left (key_left),
    .key_right(key_right),
    .map_x    (map_x),
    .map_y    (map_y),
    .map_wall (map_wall),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .cur_dir  (cur_dir),
    .moved    (moved),
    .blocked  (blocked),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  function automatic logic wall_at(input logic [7:0] x, input logic [6:0] y);
    return (y == 7'd17) && (x == 8'd12 || x == 8'd13);
  endfunction

  assign map_wall = stub_map ? 1'b0 : wall_at(map_x, map_y);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
  endtask

  task automatic wait_pulse(output int lat, output logic mv, output logic bl);
    lat = 1;
    while (!(moved || blocked) && lat < 6) begin
      step();
      lat++;
    end
    mv = moved;
    bl = blocked;
  endtask

  // Register the keys one cycle ahead, release them (the request must persist), then tick.
  task automatic do_tick(input logic [3:0] k, output int lat, output logic mv, output logic bl);
    set_keys(k);
    step();
    set_keys(4'b0000);
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_pulse(lat, mv, bl);
  endtask

  task automatic run_vec(input int i);
    int   lat;
    logic mv, bl;
    stub_map = vecs[i].stub;
    do_tick(vecs[i].keys, lat, mv, bl);
    check($sformatf("v%0d latency", i), lat, vecs[i].elat);
    check($sformatf("v%0d moved", i), int'(mv), int'(vecs[i].emoved));
    check($sformatf("v%0d blocked", i), int'(bl), int'(!vecs[i].emoved));
    check($sformatf("v%0d pos_x", i), int'(pos_x), vecs[i].ex);
    check($sformatf("v%0d pos_y", i), int'(pos_y), vecs[i].ey);
    check($sformatf("v%0d cur_dir", i), int'(cur_dir), vecs[i].edir);
    step();
    check($sformatf("v%0d pulse width", i), int'(moved || blocked), 0);
  endtask

  initial begin
    int   lat, pulses;
    logic mv, bl;

    //            keys     stub  x   y   dir lat moved
    vecs[0]  = '{4'b1000, 1'b0, 13, 18, 4, 3, 1'b0};  // up into wall, no heading yet
    vecs[1]  = '{4'b0010, 1'b0, 12, 18, 2, 2, 1'b1};  // first left move
    vecs[2]  = '{4'b1000, 1'b0, 11, 18, 2, 3, 1'b1};  // up walled, falls back to left
    vecs[3]  = '{4'b0000, 1'b0, 11, 17, 0, 2, 1'b1};  // persisting up request now succeeds
    vecs[4]  = '{4'b0100, 1'b0, 11, 18, 1, 2, 1'b1};  // reversal
    vecs[5]  = '{4'b0001, 1'b0, 12, 18, 3, 2, 1'b1};
    vecs[6]  = '{4'b1001, 1'b0, 13, 18, 3, 3, 1'b1};  // up wins priority, walled, right continues
    vecs[7]  = '{4'b0011, 1'b0, 12, 18, 2, 2, 1'b1};  // left beats right
    vecs[8]  = '{4'b0010, 1'b1, 26, 10, 2, 2, 1'b1};  // tunnel wrap left
    vecs[9]  = '{4'b0001, 1'b1,  0, 10, 3, 2, 1'b1};  // tunnel wrap right
    vecs[10] = '{4'b0001, 1'b1,  1, 10, 3, 2, 1'b1};
    vecs[11] = '{4'b0100, 1'b1,  1, 11, 1, 2, 1'b1};
    vecs[12] = '{4'b0010, 1'b1,  0, 11, 2, 2, 1'b1};
    vecs[13] = '{4'b0010, 1'b1,  0, 11, 2, 3, 1'b0};  // no wrap off row 11

    // Reset values
    step();
    step();
    check("reset pos_x", int'(pos_x), 13);
    check("reset pos_y", int'(pos_y), 18);
    check("reset map_x", int'(map_x), 13);
    check("reset map_y", int'(map_y), 18);
    check("reset cur_dir", int'(cur_dir), 4);
    check("reset pulses", int'(moved || blocked), 0);
    check("reset busy", int'(busy), 0);
    check("reset state", int'(dbg_state), 0);
    resetn = 1'b1;
    step();

    for (int i = 0; i <= 7; i++) run_vec(i);

    // Walk to (0,10) over an open map
    stub_map = 1'b1;
    for (int i = 0; i < 8; i++) do_tick(4'b1000, lat, mv, bl);
    for (int i = 0; i < 12; i++) do_tick(4'b0010, lat, mv, bl);
    check("walk pos_x", int'(pos_x), 0);
    check("walk pos_y", int'(pos_y), 10);

    for (int i = 8; i <= 13; i++) run_vec(i);
    check("map_x held on illegal", int'(map_x), 0);

    // Back-to-back ticks: second one must be dropped
    set_keys(4'b0001);
    step();
    set_keys(4'b0000);
    tick = 1'b1;
    step();
    step();
    tick = 1'b0;
    pulses = int'(moved) + int'(blocked);
    for (int i = 0; i < 6; i++) begin
      step();
      pulses += int'(moved) + int'(blocked);
    end
    check("double tick pulses", pulses, 1);
    check("double tick pos_x", int'(pos_x), 1);

    // Key change coincident with tick uses the old request (right, not down)
    key_down = 1'b1;
    tick = 1'b1;
    step();
    key_down = 1'b0;
    tick = 1'b0;
    wait_pulse(lat, mv, bl);
    check("same-cycle key latency", lat, 2);
    check("same-cycle key pos_x", int'(pos_x), 2);
    check("same-cycle key pos_y", int'(pos_y), 11);
    check("same-cycle key cur_dir", int'(cur_dir), 3);
    step();

    // Reset during TRY_NEXT abandons the move
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("busy in try_next", int'(busy), 1);
    #2;
    resetn = 1'b0;
    #1;
    check("mid reset pos_x", int'(pos_x), 13);
    check("mid reset pos_y", int'(pos_y), 18);
    check("mid reset map_x", int'(map_x), 13);
    check("mid reset cur_dir", int'(cur_dir), 4);
    check("mid reset busy", int'(busy), 0);
    step();
    resetn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      pulses += int'(moved) + int'(blocked);
    end
    check("mid reset no pulse", pulses, 0);
    check("mid reset pos kept", int'(pos_y), 18);

    // First tick after reset release is honoured (next_dir is NONE, so it blocks)
    resetn = 1'b0;
    tick = 1'b1;
    #3;
    resetn = 1'b1;
    step();
    tick = 1'b0;
    check("first tick busy", int'(busy), 1);
    wait_pulse(lat, mv, bl);
    check("first tick latency", lat, 3);
    check("first tick blocked", int'(bl), 1);
    check("first tick pos_x", int'(pos_x), 13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pacman_mover.md
PACMAN_MOVER -- requirements
Module: pacman_mover

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): START_X, 13, reset column; START_Y, 18, reset row; MAP_W, 27, column count, so legal x is 0..26; MAP_H, 24, row count, so legal y is 0..23; TUNNEL_Y, 10, the row on which x wraps.
REQ-002 clock  in  1  rising-edge system clock.
REQ-003 resetn  in  1  reset, asynchronous and active-low.
REQ-004 tick  in  1  one-cycle move-request strobe.
REQ-005 key_up, key_down, key_left, key_right  in  1 each  player direction requests, level-sensitive.
REQ-006 map_x  out  8  registered column address to the map LUT.
REQ-007 map_y  out  7  registered row address to the map LUT.
REQ-008 map_wall  in  1  combinational wall bit for (map_x, map_y); 1 = wall.
REQ-009 pos_x  out  8  current column.
REQ-010 pos_y  out  7  current row.
REQ-011 cur_dir  out  3  current heading.
REQ-012 moved  out  1  one-cycle pulse when a move commits.
REQ-013 blocked  out  1  one-cycle pulse when a tick yields no move.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Direction encoding SHALL be UP=0, DOWN=1, LEFT=2, RIGHT=3, NONE=4; UP decrements y and LEFT decrements x.
REQ-016 Each cycle, if any key is high, next_dir SHALL register the highest-priority key (up > down > left > right); otherwise next_dir holds.
REQ-017 The FSM states SHALL be IDLE, TRY_NEXT and TRY_CUR.
REQ-018 IDLE + tick: register map_x/map_y with the target tile of the registered next_dir and go to TRY_NEXT; without tick, stay in IDLE.
REQ-019 TRY_NEXT with target legal and map_wall=0: pos takes the target, cur_dir takes next_dir, moved pulses, go to IDLE.
REQ-020 TRY_NEXT otherwise: register map_x/map_y with the target tile of cur_dir and go to TRY_CUR.
REQ-021 TRY_CUR with cur_dir!=NONE, target legal and map_wall=0: pos takes the target, moved pulses, go to IDLE.
REQ-022 TRY_CUR otherwise: blocked pulses, cur_dir is unchanged, go to IDLE.
REQ-023 Latency SHALL be fixed: pos updates 2 clocks after a tick edge if next_dir succeeds, else 3; moved/blocked are asserted in the same cycle pos updates.
REQ-024 Any tick while busy=1 SHALL be ignored and not queued.
REQ-025 A key change in the same cycle as tick SHALL NOT affect that tick, because the tick uses the pre-edge next_dir.
REQ-026 Target rules: x-1 from x=0 on row TUNNEL_Y gives 26; x+1 from 26 on TUNNEL_Y gives 0.
REQ-027 Any other target outside 0..MAP_W-1 or 0..MAP_H-1, or a target for NONE, SHALL be treated as a wall regardless of map_wall.
REQ-028 map_x SHALL never be driven outside 0..26; on an illegal target it holds its previous value.
REQ-029 Reversal (next_dir opposite to cur_dir) SHALL be permitted like any other direction.
REQ-030 next_dir SHALL persist after it is adopted.

Reset
REQ-031 While resetn=0, state SHALL be forced immediately to: pos (START_X, START_Y), map_x/map_y equal to pos, cur_dir=NONE, next_dir=NONE, state IDLE, moved=0, blocked=0.
REQ-032 Reset asserted mid-TRY_NEXT or mid-TRY_CUR SHALL abandon the move, with no moved or blocked pulse.
REQ-033 The first tick SHALL be honoured on the first edge after resetn rises.

Structure
REQ-034 Direction codes, MAP_W, MAP_H and TUNNEL_Y SHALL live in the shared package pacman_pkg, for reuse by the ghost movers.
REQ-035 Target computation (position plus direction, giving target and a legal flag, with wrap) SHALL be one combinational sub-module named tile_step.
REQ-036 map_lut SHALL be instantiated by the parent, not inside this block.

Verification
REQ-037 Bench with the real map_lut: after reset, hold key_left, pulse tick -> two clocks later pos=(12,18), cur_dir=LEFT, moved=1.
REQ-038 From reset, key_up, tick -> (13,17) is a wall and cur_dir=NONE, so blocked pulses 3 clocks after the tick and pos stays (13,18).
REQ-039 At (12,18) heading LEFT with next_dir=UP, and a wall above, tick -> TRY_CUR used, pos=(11,18) at 3 clocks, cur_dir stays LEFT.
REQ-040 Stub map_wall=0, pos forced to (0,10), LEFT, tick -> pos=(26,10); then RIGHT, tick -> pos=(0,10); on row 11, LEFT at x=0 -> blocked.
REQ-041 Tick on consecutive cycles -> the second tick is ignored, giving exactly one moved or blocked pulse; resetn low during TRY_NEXT -> pos=(13,18), no pulse.
